rv_ctl_ws: RTL

//  Multicycle RISC-V control FSM, next generation. Drives the datapath and memory of the multicycle core.

---
 rtl/rv_pkg.sv | 58 +++++
 rtl/rv_wait_timer.sv | 26 ++
 rtl/rv_ctl_ws.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared encodings, trap causes and state enum for the multicycle RISC-V control
package rv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    localparam logic       PC_INC    = 1'b0;
    localparam logic       PC_ALU    = 1'b1;

    localparam logic [1:0] WB_PC     = 2'd0;
    localparam logic [1:0] WB_ALUOUT = 2'd1;
    localparam logic [1:0] WB_MDR    = 2'd2;

    localparam logic [1:0] IMM_L     = 2'd0;
    localparam logic [1:0] IMM_S     = 2'd1;
    localparam logic [1:0] IMM_B     = 2'd2;
    localparam logic [1:0] IMM_J     = 2'd3;

    localparam logic       ALUA_REG  = 1'b0;
    localparam logic       ALUA_PCC  = 1'b1;
    localparam logic       ALUB_REG  = 1'b0;
    localparam logic       ALUB_IMM  = 1'b1;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;

    typedef enum logic [1:0] {
        TC_NONE     = 2'd0,
        TC_ILLEGAL  = 2'd1,
        TC_FETCH_TO = 2'd2,
        TC_DATA_TO  = 2'd3
    } trap_cause_e;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_LW_MEM,
        S_LW_WB,
        S_SW_MEM,
        S_ALU_EXEC,
        S_ALU_WB,
        S_BR_EXEC,
        S_JAL_EXEC,
        S_TRAP
    } state_e;

endpackage

// File: rtl/rv_wait_timer.sv
// rtl/rv_wait_timer.sv - wait-state counter with MAX_WAIT timeout compare
module rv_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    localparam int W = $clog2(MAX_WAIT + 1);

    logic [W-1:0] wait_cnt;

    // The FSM leaves the wait state on timeout, so the count never passes MAX_WAIT.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            wait_cnt <= '0;
        end else if (en) begin
            wait_cnt <= wait_cnt + W'(1);
        end
    end

    assign timeout = (wait_cnt == W'(MAX_WAIT));

endmodule

// File: rtl/rv_ctl_ws.sv
// rtl/rv_ctl_ws.sv - multicycle RISC-V control FSM with memory wait states, trap and retire counter
module rv_ctl_ws
    import rv_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32,
    parameter bit EN_ITYPE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             memrw,
    output logic             pcsourse,
    output logic             pcwrite,
    output logic             pccen,
    output logic             irwrite,
    output logic             mdrwrite,
    output logic             regwen,
    output logic [1:0]       wbsel,
    output logic [1:0]       immsel,
    output logic             asel,
    output logic             bsel,
    output logic [3:0]       alusel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);
    state_e      state, state_next;
    trap_cause_e cause_q, cause_next;
    logic        retire, wait_en, timeout;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       is_lw, is_sw, is_op, is_op_imm, is_beq, is_bne, is_jal;
    logic       unused_instr;

    assign opcode    = instr[6:0];
    assign f3        = instr[14:12];
    assign is_lw     = (opcode == OPC_LOAD)   && (f3 == F3_LW);
    assign is_sw     = (opcode == OPC_STORE)  && (f3 == F3_SW);
    assign is_op     = (opcode == OPC_OP);
    assign is_op_imm = (opcode == OPC_OP_IMM) && EN_ITYPE;
    assign is_beq    = (opcode == OPC_BRANCH) && (f3 == F3_BEQ);
    assign is_bne    = (opcode == OPC_BRANCH) && (f3 == F3_BNE);
    assign is_jal    = (opcode == OPC_JAL);
    // Register and immediate fields are consumed by the datapath, not here.
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    rv_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_next != state),
        .en      (wait_en),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_FETCH;
            cause_q <= TC_NONE;
            retired <= '0;
        end else begin
            state <= state_next;
            if (state_next == S_TRAP && state != S_TRAP) begin
                cause_q <= cause_next;
            end
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        cause_next = TC_NONE;
        retire     = 1'b0;
        wait_en    = 1'b0;
        mem_req    = 1'b0;
        memrw      = 1'b0;
        pcsourse   = PC_INC;
        pcwrite    = 1'b0;
        pccen      = 1'b0;
        irwrite    = 1'b0;
        mdrwrite   = 1'b0;
        regwen     = 1'b0;
        wbsel      = WB_PC;
        immsel     = IMM_B;
        asel       = ALUA_REG;
        bsel       = ALUB_REG;
        alusel     = ALU_ADD;

        unique case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    irwrite    = 1'b1;
                    pccen      = 1'b1;
                    pcwrite    = 1'b1;
                    state_next = S_DECODE;
                end else begin
                    wait_en = 1'b1;
                    if (timeout) begin
                        state_next = S_TRAP;
                        cause_next = TC_FETCH_TO;
                    end
                end
            end
            S_DECODE: begin
                // Speculatively compute the branch target while dispatching.
                immsel = IMM_B;
                asel   = ALUA_PCC;
                bsel   = ALUB_IMM;
                if (is_lw || is_sw)              state_next = S_MEM_ADDR;
                else if (is_op || is_op_imm)     state_next = S_ALU_EXEC;
                else if (is_beq || is_bne)       state_next = S_BR_EXEC;
                else if (is_jal)                 state_next = S_JAL_EXEC;
                else begin
                    state_next = S_TRAP;
                    cause_next = TC_ILLEGAL;
                end
            end
            S_MEM_ADDR: begin
                bsel       = ALUB_IMM;
                immsel     = is_lw ? IMM_L : IMM_S;
                state_next = is_lw ? S_LW_MEM : S_SW_MEM;
            end
            S_LW_MEM, S_SW_MEM: begin
                mem_req = 1'b1;
                memrw   = (state == S_SW_MEM);
                if (mem_ready) begin
                    if (state == S_LW_MEM) begin
                        mdrwrite   = 1'b1;
                        state_next = S_LW_WB;
                    end else begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                end else begin
                    wait_en = 1'b1;
                    if (timeout) begin
                        state_next = S_TRAP;
                        cause_next = TC_DATA_TO;
                    end
                end
            end
            S_LW_WB: begin
                wbsel      = WB_MDR;
                regwen     = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_ALU_EXEC: begin
                if (is_op_imm) begin
                    bsel   = ALUB_IMM;
                    immsel = IMM_L;
                    alusel = {f3, (f3 == F3_SRX) ? instr[30] : 1'b0};
                end else begin
                    alusel = {f3, instr[30]};
                end
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                wbsel      = WB_ALUOUT;
                regwen     = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BR_EXEC: begin
                alusel     = ALU_SUB;
                pcsourse   = PC_ALU;
                pcwrite    = is_bne ? !zero : zero;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL_EXEC: begin
                immsel     = IMM_J;
                asel       = ALUA_PCC;
                bsel       = ALUB_IMM;
                pcsourse   = PC_ALU;
                pcwrite    = 1'b1;
                regwen     = 1'b1;
                wbsel      = WB_PC;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    assign trap       = (state == S_TRAP);
    assign trap_cause = cause_q;

endmodule
